// File: rtl/mem_ctrl_router.sv
// mem_ctrl_router: N-region address decoder plus single-outstanding request
// router between one master and N_REGIONS slave ports.
//   clk, rst_n     : clock, asynchronous active-low reset
//   m_req_*        : master request (valid/ready, addr, we, wdata, be)
//   m_rsp_*        : master response (one-cycle valid pulse, rdata, err)
//   s_req_*        : slave request (one-hot valid, per-slave ready, shared payload)
//   s_rsp_*        : per-slave response valid and packed read data (slice i)
// Optional build macro MEM_CTRL_ROUTER_MISALIGN_CHK_EN rejects misaligned
// requests (non-contiguous byte enables, or a full-word access at a non-zero
// byte offset) with an error response, exactly like an unmapped address.
module mem_ctrl_router #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_REGIONS   = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE =
    {32'h11000000, 32'h10100000, 32'h10010000, 32'h00400000},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_END =
    {32'hFFFFFFFF, 32'h101000FF, 32'h100100FF, 32'h00400FFF},
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        m_req_valid,
  output logic                        m_req_ready,
  input  logic [ADDR_W-1:0]           m_req_addr,
  input  logic                        m_req_we,
  input  logic [DATA_W-1:0]           m_req_wdata,
  input  logic [DATA_W/8-1:0]         m_req_be,
  output logic                        m_rsp_valid,
  output logic [DATA_W-1:0]           m_rsp_rdata,
  output logic                        m_rsp_err,
  output logic [N_REGIONS-1:0]        s_req_valid,
  input  logic [N_REGIONS-1:0]        s_req_ready,
  output logic [ADDR_W-1:0]           s_req_addr,
  output logic                        s_req_we,
  output logic [DATA_W-1:0]           s_req_wdata,
  output logic [DATA_W/8-1:0]         s_req_be,
  input  logic [N_REGIONS-1:0]        s_rsp_valid,
  input  logic [N_REGIONS*DATA_W-1:0] s_rsp_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned SEL_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   we_q, we_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [BE_W-1:0]        be_q, be_d;
  logic                   m_req_ready_q, m_req_ready_d;
  logic                   m_rsp_valid_q, m_rsp_valid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [N_REGIONS-1:0]   s_req_valid_q, s_req_valid_d;

  logic                   hit_c;
  logic [SEL_W-1:0]       hit_sel_c;
  logic                   reject_c;
  logic                   timeout_c;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_c     = 1'b0;
    hit_sel_c = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (m_req_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
          m_req_addr <= REGION_END[i*ADDR_W +: ADDR_W]) begin
        hit_c     = 1'b1;
        hit_sel_c = SEL_W'(i);
      end
    end
  end

`ifdef MEM_CTRL_ROUTER_MISALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);
  logic misalign_c;

  // Contiguous lanes have at most one 0->1 rise walking up from lane 0.
  always_comb begin : misalign_chk
    int unsigned rises;
    logic        prev;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (m_req_be[i] && !prev) rises = rises + 32'd1;
      prev = m_req_be[i];
    end
    misalign_c = (rises > 32'd1) ||
                 (((m_req_addr & OFF_MASK) != '0) && (&m_req_be));
  end

  assign reject_c = !hit_c || misalign_c;
`else
  assign reject_c = !hit_c;
`endif

  // Count reaches TIMEOUT_CYC at the end of this REQ/WAIT cycle.
  assign timeout_c = (32'(cnt_q) + 32'd1) >= TIMEOUT_CYC;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    m_req_ready_d = m_req_ready_q;
    m_rsp_valid_d = 1'b0;
    rdata_d       = rdata_q;
    err_d         = err_q;
    s_req_valid_d = s_req_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (m_req_valid) begin
          addr_d        = m_req_addr;
          we_d          = m_req_we;
          wdata_d       = m_req_wdata;
          be_d          = m_req_be;
          sel_d         = hit_sel_c;
          m_req_ready_d = 1'b0;
          if (reject_c) begin
            state_d       = S_RESP;
            m_rsp_valid_d = 1'b1;
            rdata_d       = '0;
            err_d         = 1'b1;
          end else begin
            state_d       = S_REQ;
            cnt_d         = '0;
            s_req_valid_d = N_REGIONS'(1) << hit_sel_c;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A same-cycle response from the slave is only a handshake here.
        if (timeout_c) begin
          state_d       = S_RESP;
          s_req_valid_d = '0;
          m_rsp_valid_d = 1'b1;
          rdata_d       = '0;
          err_d         = 1'b1;
        end else if (s_req_ready[sel_q]) begin
          state_d       = S_WAIT;
          s_req_valid_d = '0;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response beats a timeout landing in the same cycle.
        if (s_rsp_valid[sel_q]) begin
          state_d       = S_RESP;
          m_rsp_valid_d = 1'b1;
          rdata_d       = we_q ? '0 : s_rsp_rdata[sel_q*DATA_W +: DATA_W];
          err_d         = 1'b0;
        end else if (timeout_c) begin
          state_d       = S_RESP;
          m_rsp_valid_d = 1'b1;
          rdata_d       = '0;
          err_d         = 1'b1;
        end
      end

      S_RESP: begin
        state_d       = S_IDLE;
        m_req_ready_d = 1'b1;
        rdata_d       = '0;
        err_d         = 1'b0;
      end

      default: begin
        state_d       = S_IDLE;
        m_req_ready_d = 1'b1;
        s_req_valid_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      be_q          <= '0;
      m_req_ready_q <= 1'b1;
      m_rsp_valid_q <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      s_req_valid_q <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      m_req_ready_q <= m_req_ready_d;
      m_rsp_valid_q <= m_rsp_valid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      s_req_valid_q <= s_req_valid_d;
    end
  end

  assign m_req_ready = m_req_ready_q;
  assign m_rsp_valid = m_rsp_valid_q;
  assign m_rsp_rdata = rdata_q;
  assign m_rsp_err   = err_q;
  assign s_req_valid = s_req_valid_q;
  assign s_req_addr  = addr_q;
  assign s_req_we    = we_q;
  assign s_req_wdata = wdata_q;
  assign s_req_be    = be_q;

endmodule

// File: tb/tb_mem_ctrl_router.sv
// tb_mem_ctrl_router: directed bench for mem_ctrl_router. Each transaction's
// expected timeline (request window, response cycle, response payload) is
// derived from the address map, slave behaviour and timeout budget, then a
// single negedge process compares the DUT against that timeline every cycle.
module tb_mem_ctrl_router;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N      = 4;
  localparam int unsigned BE_W   = 4;
  localparam int          T      = 8;

`ifdef MEM_CTRL_ROUTER_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [31:0] RBASE [4] = '{32'h00400000, 32'h10010000, 32'h10100000, 32'h11000000};
  localparam logic [31:0] REND  [4] = '{32'h00400FFF, 32'h100100FF, 32'h101000FF, 32'hFFFFFFFF};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 m_req_valid;
  logic                 m_req_ready;
  logic [ADDR_W-1:0]    m_req_addr;
  logic                 m_req_we;
  logic [DATA_W-1:0]    m_req_wdata;
  logic [BE_W-1:0]      m_req_be;
  logic                 m_rsp_valid;
  logic [DATA_W-1:0]    m_rsp_rdata;
  logic                 m_rsp_err;
  logic [N-1:0]         s_req_valid;
  logic [N-1:0]         s_req_ready;
  logic [ADDR_W-1:0]    s_req_addr;
  logic                 s_req_we;
  logic [DATA_W-1:0]    s_req_wdata;
  logic [BE_W-1:0]      s_req_be;
  logic [N-1:0]         s_rsp_valid;
  logic [N*DATA_W-1:0]  s_rsp_rdata;

  mem_ctrl_router #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_we(m_req_we),
    .m_req_wdata(m_req_wdata), .m_req_be(m_req_be),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(s_req_addr), .s_req_we(s_req_we),
    .s_req_wdata(s_req_wdata), .s_req_be(s_req_be),
    .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle, written by the driver.
  logic              chk_en = 1'b0;
  logic              exp_ready = 1'b1;
  logic [N-1:0]      exp_sv = '0;
  logic              exp_rspv = 1'b0;
  logic [31:0]       exp_rdata = '0;
  logic              exp_err = 1'b0;
  logic [31:0]       exp_addr = '0;
  logic              exp_we = 1'b0;
  logic [31:0]       exp_wdata = '0;
  logic [3:0]        exp_be = '0;
  int                k_now = 0;

  // Last observed response, for literal spot checks.
  int                rsp_k = -1;
  logic [31:0]       rsp_data = '0;
  logic              rsp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= RBASE[i] && a <= REND[i]) return i;
    return -1;
  endfunction

  function automatic bit model_misaligned(input logic [31:0] a, input logic [3:0] be);
    int x;
    bit gap;
    x = int'(be);
    if (x != 0) while ((x % 2) == 0) x = x / 2;
    gap = (x & (x + 1)) != 0;
    return CHK_EN && (gap || ((a % 4) != 0 && be == 4'hF));
  endfunction

  // Single compare process against the per-cycle expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_req_ready", 64'(m_req_ready), 64'(exp_ready));
      check("s_req_valid", 64'(s_req_valid), 64'(exp_sv));
      check("m_rsp_valid", 64'(m_rsp_valid), 64'(exp_rspv));
      if (exp_rspv) begin
        check("m_rsp_rdata", 64'(m_rsp_rdata), 64'(exp_rdata));
        check("m_rsp_err",   64'(m_rsp_err),   64'(exp_err));
      end
      if (exp_sv != '0) begin
        check("s_req_addr",  64'(s_req_addr),  64'(exp_addr));
        check("s_req_we",    64'(s_req_we),    64'(exp_we));
        check("s_req_wdata", 64'(s_req_wdata), 64'(exp_wdata));
        check("s_req_be",    64'(s_req_be),    64'(exp_be));
      end
      if (m_rsp_valid) begin
        rsp_k    = k_now;
        rsp_data = m_rsp_rdata;
        rsp_err  = m_rsp_err;
      end
    end
  end

  // One transaction: accept at k=0; slave ready at k=1+rd; response at
  // k=2+rd+rspd unless noresp. rst_at>0 pulses reset at that cycle.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] be, input int rd, input int rspd, input bit noresp,
                         input logic [31:0] sdata, input bit noise, input int rst_at);
    int sel, fin, req_end, rsp_cyc, last;
    bit to;
    logic [N-1:0] oh;
    sel = model_sel(addr);
    if (model_misaligned(addr, be)) sel = -1;
    oh      = (sel >= 0) ? (N'(1) << sel) : '0;
    req_end = (1 + rd > T) ? T : 1 + rd;
    rsp_cyc = 2 + rd + rspd;
    to      = 1'b0;
    if (sel < 0) fin = 1;
    else if (1 + rd > T || noresp || rsp_cyc > T) begin to = 1'b1; fin = T + 1; end
    else fin = rsp_cyc + 1;
    last  = (rst_at > 0) ? rst_at + 5 : fin + 1;
    rsp_k = -1;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      k_now       = k;
      m_req_valid = (k == 0);
      m_req_addr  = addr;
      m_req_we    = we;
      m_req_wdata = wdata;
      m_req_be    = be;
      s_req_ready = noise ? ~oh : '0;
      s_rsp_valid = noise ? ~oh : '0;
      if (sel >= 0 && k == 1 + rd) begin
        s_req_ready = s_req_ready | oh;
        if (noise) s_rsp_valid = s_rsp_valid | oh;
      end
      if (sel >= 0 && !noresp && k == rsp_cyc) s_rsp_valid = s_rsp_valid | oh;
      for (int i = 0; i < N; i++)
        s_rsp_rdata[i*DATA_W +: DATA_W] = (i == sel) ? sdata : (32'hBAD00000 | 32'(i));
      exp_addr = addr; exp_we = we; exp_wdata = wdata; exp_be = be;
      if (rst_at > 0 && k >= rst_at) begin
        rst_n     = (k >= rst_at + 2);
        exp_ready = 1'b1; exp_sv = '0; exp_rspv = 1'b0;
      end else if (k == 0 || k > fin) begin
        exp_ready = 1'b1; exp_sv = '0; exp_rspv = 1'b0;
      end else begin
        exp_ready = 1'b0;
        exp_sv    = (k <= req_end) ? oh : '0;
        exp_rspv  = (k == fin);
        exp_rdata = (!to && sel >= 0 && !we) ? sdata : 32'h0;
        exp_err   = (sel < 0) || to;
      end
    end
    s_req_ready = '0;
    s_rsp_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; m_req_valid = 1'b0; m_req_addr = '0; m_req_we = 1'b0;
    m_req_wdata = '0; m_req_be = '0; s_req_ready = '0; s_rsp_valid = '0; s_rsp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_req_ready", 64'(m_req_ready), 64'd1);
    check("rst_m_rsp_valid", 64'(m_rsp_valid), 64'd0);
    check("rst_m_rsp_rdata", 64'(m_rsp_rdata), 64'd0);
    check("rst_m_rsp_err",   64'(m_rsp_err),   64'd0);
    check("rst_s_req_valid", 64'(s_req_valid), 64'd0);
    check("rst_s_req_addr",  64'(s_req_addr),  64'd0);
    check("rst_s_req_wdata", 64'(s_req_wdata), 64'd0);
    check("rst_s_req_be",    64'(s_req_be),    64'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    check("model_sel_uart", 64'(model_sel(32'h10100000)), 64'd2);
    check("model_sel_miss", 64'(model_sel(32'h10000000)), 64'(-1));

    // Read slave0, immediate ready, response next cycle.
    run_txn(32'h00400010, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 0);
    check("t1_rsp_cycle", 64'(rsp_k), 64'd3);
    check("t1_rdata", 64'(rsp_data), 64'hDEADBEEF);
    // Write slave1, ready held off 3 cycles, with ignored-response noise.
    run_txn(32'h10010004, 1'b1, 32'hCAFEF00D, 4'hF, 3, 1, 1'b0, 32'h12345678, 1'b1, 0);
    check("t2_rsp_cycle", 64'(rsp_k), 64'd7);
    check("t2_rdata", 64'(rsp_data), 64'd0);
    // Unmapped read.
    run_txn(32'h10000000, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b1, 0);
    check("t3_rsp_cycle", 64'(rsp_k), 64'd1);
    check("t3_err", 64'(rsp_err), 64'd1);
    // UART never responds: timeout.
    run_txn(32'h10100000, 1'b0, 32'h0, 4'hF, 0, 0, 1'b1, 32'h0, 1'b0, 0);
    check("t4_rsp_cycle", 64'(rsp_k), 64'd9);
    check("t4_err", 64'(rsp_err), 64'd1);
    // Response on the timeout cycle wins.
    run_txn(32'h10100010, 1'b0, 32'h0, 4'hF, 1, 5, 1'b0, 32'h0BADF00D, 1'b0, 0);
    check("t5_rsp_cycle", 64'(rsp_k), 64'd9);
    check("t5_err", 64'(rsp_err), 64'd0);
    check("t5_rdata", 64'(rsp_data), 64'h0BADF00D);
    // Slave never ready: timeout while requesting.
    run_txn(32'h00400100, 1'b0, 32'h0, 4'hF, 8, 0, 1'b0, 32'h77777777, 1'b0, 0);
    check("t6_err", 64'(rsp_err), 64'd1);
    // Reset in WAIT: no response, late slave response ignored.
    run_txn(32'h00400020, 1'b0, 32'h0, 4'hF, 0, 2, 1'b0, 32'h99999999, 1'b0, 2);
    check("t7_no_rsp", 64'(rsp_k), 64'(-1));
    // Normal read on slave3 after the reset.
    run_txn(32'h11000000, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h55AA55AA, 1'b0, 0);
    check("t8_rsp_cycle", 64'(rsp_k), 64'd3);
    check("t8_rdata", 64'(rsp_data), 64'h55AA55AA);
    // Full-word read at byte offset 2.
    run_txn(32'h11000002, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h31415926, 1'b0, 0);
    check("t9_err", 64'(rsp_err), CHK_EN ? 64'd1 : 64'd0);
    check("t9_rsp_cycle", 64'(rsp_k), CHK_EN ? 64'd1 : 64'd3);
    // Region boundaries and non-contiguous byte enables.
    run_txn(32'h00400FFF, 1'b1, 32'h01020304, 4'b0101, 0, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 0);
    run_txn(32'h00401000, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0, 0);
    run_txn(32'h100100FF, 1'b0, 32'h0, 4'b1000, 0, 2, 1'b0, 32'hA5A5A5A5, 1'b1, 0);
    run_txn(32'hFFFFFFFF, 1'b0, 32'h0, 4'b1000, 2, 0, 1'b0, 32'h13579BDF, 1'b0, 0);
    run_txn(32'h10FFFFFF, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
